// File: rtl/filter_pipe_if.sv
// Producer/consumer bundle for filter_pipe: input item, output item,
// flush request and in-flight count. The slave modport is the pipe
// itself; the master modport is whoever drives and consumes it.
interface filter_pipe_if #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
);
    localparam int CW = $clog2(STAGES + 1);

    logic [WIDTH-1:0] io_x_data;
    logic             io_x_parity;
    logic             io_x_valid;
    logic             io_x_ready;
    logic             io_flush;
    logic [WIDTH-1:0] io_y_data;
    logic             io_y_parity;
    logic             io_y_valid;
    logic             io_y_ready;
    logic [CW-1:0]    io_count;

    modport slave (
        input  io_x_data,
        input  io_x_parity,
        input  io_x_valid,
        input  io_flush,
        input  io_y_ready,
        output io_x_ready,
        output io_y_data,
        output io_y_parity,
        output io_y_valid,
        output io_count
    );

    modport master (
        output io_x_data,
        output io_x_parity,
        output io_x_valid,
        output io_flush,
        output io_y_ready,
        input  io_x_ready,
        input  io_y_data,
        input  io_y_parity,
        input  io_y_valid,
        input  io_count
    );
endinterface

// File: rtl/filter_pipe.sv
// Elastic chain of STAGES registered filter stages. Each stage rotates
// the (WIDTH+1)-bit word {data,parity} left by one, so the whole pipe
// rotates it by STAGES. Every stage has its own valid bit; a stage loads
// whenever it is empty or the stage after it is loading, which lets
// bubbles collapse while the consumer stalls. A flush empties the pipe
// without touching data/parity registers.
module filter_pipe #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic          clk,
    input  logic          reset,
    filter_pipe_if.slave  io
);
    localparam int CW = $clog2(STAGES + 1);
    localparam logic [CW-1:0] ONE_C = CW'(1'b1);

    // One filter step: {d,p} rotated left by one bit.
    // Result layout is {d', p'}.
    function automatic logic [WIDTH:0] stage_xform(
        input logic [WIDTH-1:0] d,
        input logic             p
    );
        return {d[WIDTH-2:0], p, d[WIDTH-1]};
    endfunction

    logic [STAGES-1:0]            v_q;
    logic [STAGES-1:0]            v_d;
    logic [STAGES-1:0][WIDTH-1:0] data_q;
    logic [STAGES-1:0][WIDTH-1:0] data_d;
    logic [STAGES-1:0]            parity_q;
    logic [STAGES-1:0]            parity_d;
    logic [CW-1:0]                count_q;
    logic [CW-1:0]                count_d;

    logic [STAGES-1:0]            en_s;
    logic [STAGES-1:0]            up_valid_s;
    logic [STAGES-1:0][WIDTH-1:0] up_data_s;
    logic [STAGES-1:0]            up_parity_s;
    logic                         x_hs_s;
    logic                         y_hs_s;

    // Load enables: stage k may load unless it and every stage after it
    // are full while the consumer is stalled.
    always_comb begin
        logic all_full;
        all_full = 1'b1;
        en_s     = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            all_full = all_full & v_q[k];
            en_s[k]  = io.io_y_ready | ~all_full;
        end
    end

    // Stage inputs: stage 0 from the producer, others from the previous stage.
    always_comb begin
        up_valid_s     = '0;
        up_data_s      = '0;
        up_parity_s    = '0;
        up_valid_s[0]  = io.io_x_valid & ~io.io_flush;
        up_data_s[0]   = io.io_x_data;
        up_parity_s[0] = io.io_x_parity;
        for (int k = 1; k < STAGES; k++) begin
            up_valid_s[k]  = v_q[k-1];
            up_data_s[k]   = data_q[k-1];
            up_parity_s[k] = parity_q[k-1];
        end
    end

    assign x_hs_s = io.io_x_valid & io.io_x_ready;
    assign y_hs_s = v_q[STAGES-1] & io.io_y_ready;

    // Next state of every stage's valid, data and parity registers.
    always_comb begin
        logic [WIDTH:0] xf;
        v_d      = v_q;
        data_d   = data_q;
        parity_d = parity_q;
        xf       = '0;
        for (int k = 0; k < STAGES; k++) begin
            xf = stage_xform(up_data_s[k], up_parity_s[k]);
            if (io.io_flush) begin
                v_d[k] = 1'b0;
            end else if (en_s[k]) begin
                v_d[k] = up_valid_s[k];
                if (up_valid_s[k]) begin
                    data_d[k]   = xf[WIDTH:1];
                    parity_d[k] = xf[0];
                end else begin
                    data_d[k]   = data_q[k];
                    parity_d[k] = parity_q[k];
                end
            end else begin
                v_d[k] = v_q[k];
            end
        end
    end

    // In-flight count: +1 on accept, -1 on emit, cleared by flush.
    always_comb begin
        count_d = count_q;
        if (io.io_flush) begin
            count_d = '0;
        end else begin
            case ({x_hs_s, y_hs_s})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
        end
    end

    // Pipeline state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q      <= '0;
            data_q   <= '0;
            parity_q <= '0;
            count_q  <= '0;
        end else begin
            v_q      <= v_d;
            data_q   <= data_d;
            parity_q <= parity_d;
            count_q  <= count_d;
        end
    end

    assign io.io_x_ready  = en_s[0] & ~io.io_flush;
    assign io.io_y_valid  = v_q[STAGES-1];
    assign io.io_y_data   = data_q[STAGES-1];
    assign io.io_y_parity = parity_q[STAGES-1];
    assign io.io_count    = count_q;

endmodule

// File: tb/tb_filter_pipe.sv
// Directed bench for filter_pipe: a 16-bit/2-stage instance for the
// main behaviour and a 4-bit/5-stage instance for the parameter sweep.
module tb_filter_pipe;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    filter_pipe_if #(.WIDTH(16), .STAGES(2)) a ();
    filter_pipe_if #(.WIDTH(4),  .STAGES(5)) b ();

    filter_pipe #(.WIDTH(16), .STAGES(2)) u0 (
        .clk   (clk),
        .reset (reset),
        .io    (a.slave)
    );

    filter_pipe #(.WIDTH(4), .STAGES(5)) u1 (
        .clk   (clk),
        .reset (reset),
        .io    (b.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        a.io_x_data = 16'h0000; a.io_x_parity = 1'b0; a.io_x_valid = 1'b0;
        a.io_flush  = 1'b0;     a.io_y_ready  = 1'b0;
        b.io_x_data = 4'h0;     b.io_x_parity = 1'b0; b.io_x_valid = 1'b0;
        b.io_flush  = 1'b0;     b.io_y_ready  = 1'b1;

        // Asynchronous reset mid-cycle, checked before any clock edge
        #3 reset = 1'b0;
        #1;
        chk("rst_y_valid",  32'(a.io_y_valid),  32'h0);
        chk("rst_y_data",   32'(a.io_y_data),   32'h0);
        chk("rst_y_parity", 32'(a.io_y_parity), 32'h0);
        chk("rst_count",    32'(a.io_count),    32'h0);
        chk("rst_x_ready",  32'(a.io_x_ready),  32'h1);
        a.io_flush = 1'b1;
        #1;
        chk("rst_x_ready_flush", 32'(a.io_x_ready), 32'h0);
        a.io_flush = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Transform: 0x8001/p1 -> 0x0007/p0, then 0x0000/p0 -> 0x0000/p0
        a.io_y_ready = 1'b1;
        a.io_x_data = 16'h8001; a.io_x_parity = 1'b1; a.io_x_valid = 1'b1;
        #1;
        chk("xf_x_ready", 32'(a.io_x_ready), 32'h1);
        tick();
        chk("xf_lat_valid", 32'(a.io_y_valid), 32'h0);
        chk("xf_lat_count", 32'(a.io_count),   32'h1);
        a.io_x_data = 16'h0000; a.io_x_parity = 1'b0; a.io_x_valid = 1'b1;
        tick();
        a.io_x_valid = 1'b0;
        chk("xf1_valid",  32'(a.io_y_valid),  32'h1);
        chk("xf1_data",   32'(a.io_y_data),   32'h0007);
        chk("xf1_parity", 32'(a.io_y_parity), 32'h0);
        chk("xf1_count",  32'(a.io_count),    32'h2);
        tick();
        chk("xf2_valid",  32'(a.io_y_valid),  32'h1);
        chk("xf2_data",   32'(a.io_y_data),   32'h0000);
        chk("xf2_parity", 32'(a.io_y_parity), 32'h0);
        chk("xf2_count",  32'(a.io_count),    32'h1);
        tick();
        chk("xf_empty_valid", 32'(a.io_y_valid), 32'h0);
        chk("xf_empty_count", 32'(a.io_count),   32'h0);

        // Streaming: 8 back-to-back items, output is value x4
        for (int i = 1; i <= 8; i++) begin
            a.io_x_data = 16'(i); a.io_x_parity = 1'b0; a.io_x_valid = 1'b1;
            tick();
            if (i == 1) begin
                chk("st_count_fill", 32'(a.io_count), 32'h1);
            end else begin
                chk("st_valid", 32'(a.io_y_valid), 32'h1);
                chk("st_data",  32'(a.io_y_data),  32'((i - 1) * 4));
                chk("st_count", 32'(a.io_count),   32'h2);
            end
        end
        a.io_x_valid = 1'b0;
        tick();
        chk("st_last_data",  32'(a.io_y_data), 32'h0020);
        chk("st_last_count", 32'(a.io_count),  32'h1);
        tick();
        chk("st_drain_valid", 32'(a.io_y_valid), 32'h0);
        chk("st_drain_count", 32'(a.io_count),   32'h0);

        // Backpressure: stall, offer 3 items, then release
        a.io_y_ready = 1'b0;
        a.io_x_data = 16'h0010; a.io_x_valid = 1'b1;
        #1;
        chk("bp_ready_a", 32'(a.io_x_ready), 32'h1);
        tick();
        a.io_x_data = 16'h0020;
        #1;
        chk("bp_ready_b", 32'(a.io_x_ready), 32'h1);
        tick();
        a.io_x_data = 16'h0030;
        #1;
        chk("bp_full_ready", 32'(a.io_x_ready), 32'h0);
        chk("bp_full_count", 32'(a.io_count),   32'h2);
        chk("bp_full_data",  32'(a.io_y_data),  32'h0040);
        chk("bp_full_valid", 32'(a.io_y_valid), 32'h1);
        tick();
        chk("bp_hold_data",  32'(a.io_y_data),  32'h0040);
        chk("bp_hold_valid", 32'(a.io_y_valid), 32'h1);
        chk("bp_hold_count", 32'(a.io_count),   32'h2);
        chk("bp_hold_ready", 32'(a.io_x_ready), 32'h0);
        a.io_y_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(a.io_x_ready), 32'h1);
        tick();
        a.io_x_valid = 1'b0;
        chk("bp_out_b",       32'(a.io_y_data), 32'h0080);
        chk("bp_out_b_count", 32'(a.io_count),  32'h2);
        tick();
        chk("bp_out_c",       32'(a.io_y_data), 32'h00C0);
        chk("bp_out_c_count", 32'(a.io_count),  32'h1);
        tick();
        chk("bp_empty_valid", 32'(a.io_y_valid), 32'h0);
        chk("bp_empty_count", 32'(a.io_count),   32'h0);

        // Flush with two items in flight and a pending input
        a.io_y_ready = 1'b0;
        a.io_x_data = 16'h0100; a.io_x_valid = 1'b1;
        tick();
        a.io_x_data = 16'h0200;
        tick();
        chk("fl_pre_count", 32'(a.io_count), 32'h2);
        a.io_x_data = 16'h0300;
        a.io_y_ready = 1'b1;
        a.io_flush = 1'b1;
        #1;
        chk("fl_x_ready", 32'(a.io_x_ready), 32'h0);
        tick();
        a.io_flush = 1'b0;
        chk("fl_y_valid", 32'(a.io_y_valid), 32'h0);
        chk("fl_count",   32'(a.io_count),   32'h0);
        #1;
        chk("fl_resume_ready", 32'(a.io_x_ready), 32'h1);
        tick();
        a.io_x_valid = 1'b0;
        chk("fl_resume_count1", 32'(a.io_count),   32'h1);
        chk("fl_resume_valid0", 32'(a.io_y_valid), 32'h0);
        tick();
        chk("fl_resume_valid", 32'(a.io_y_valid), 32'h1);
        chk("fl_resume_data",  32'(a.io_y_data),  32'h0C00);
        tick();
        chk("fl_resume_empty", 32'(a.io_count), 32'h0);

        // WIDTH=4, STAGES=5: rotate by 5 of a 5-bit word is the identity
        b.io_x_data = 4'h9; b.io_x_parity = 1'b0; b.io_x_valid = 1'b1;
        tick();
        b.io_x_data = 4'h3; b.io_x_parity = 1'b1;
        tick();
        b.io_x_valid = 1'b0;
        chk("sw_count", 32'(b.io_count), 32'h2);
        tick();
        tick();
        chk("sw_not_yet", 32'(b.io_y_valid), 32'h0);
        tick();
        chk("sw1_valid",  32'(b.io_y_valid),  32'h1);
        chk("sw1_data",   32'(b.io_y_data),   32'h9);
        chk("sw1_parity", 32'(b.io_y_parity), 32'h0);
        tick();
        chk("sw2_data",   32'(b.io_y_data),   32'h3);
        chk("sw2_parity", 32'(b.io_y_parity), 32'h1);
        tick();
        chk("sw_empty", 32'(b.io_count), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
